uart_rx_framer: RTL and testbench

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_framer_if.sv | 10 +
 rtl/uart_byte_timer.sv | 23 ++
 rtl/uart_rx_framer.sv | 138 +++++++++++++
 tb/tb_uart_rx_framer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants and encodings for the UART rx framer.
package uart_pkg;

  localparam logic [7:0] SOF = 8'h7E;

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_DATA,
    S_HOLD,
    S_CHK
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_CHK  = 2'd2,
    ERR_TMO  = 2'd3
  } err_t;

endpackage

// File: rtl/uart_rx_framer_if.sv
// Payload stream from the framer: valid/ready handshake with last-byte marker.
interface uart_rx_framer_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  modport master (output m_data, m_valid, m_last, input m_ready);
  modport slave  (input m_data, m_valid, m_last, output m_ready);
endinterface

// File: rtl/uart_byte_timer.sv
// Inter-byte silence counter; saturates at TIMEOUT_CYC and flags expiry.
module uart_byte_timer #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic clear,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LIM = W'(TIMEOUT_CYC);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n)                cnt <= '0;
    else if (clear)              cnt <= '0;
    else if (run && cnt != LIM)  cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LIM);
endmodule

// File: rtl/uart_rx_framer.sv
// Frame parser: SOF, LEN, LEN payload bytes [, CHK] from a UART rx FIFO.
// Checksum byte and XOR check are built only with UART_FRAMER_CHKSUM_EN defined.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        r_data,
  input  logic              rx_empty,
  output logic              rd_uart,
  uart_rx_framer_if.master  m,
  output logic              frame_done,
  output logic              frame_err,
  output logic [1:0]        err_code
);
  state_t     state;
  logic       pend;       // r_data holds the fetched byte this cycle
  logic [7:0] rem;
`ifdef UART_FRAMER_CHKSUM_EN
  logic [7:0] xr;
`endif

  logic cap, counting, run, tmo, expired, going_hold, tmr_clr;

  assign cap        = pend;
  assign counting   = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
  assign run        = counting && !rd_uart && !pend;
  assign tmo        = counting && expired && !rd_uart && !pend;
  assign tmr_clr    = cap || !counting;
  // No new fetch while a byte is, or is about to be, parked on m_data.
  assign going_hold = ((state == S_DATA) && cap) || ((state == S_HOLD) && !m.m_ready);

  uart_byte_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run),
    .clear   (tmr_clr),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_HUNT;
      pend       <= 1'b0;
      rem        <= '0;
      rd_uart    <= 1'b0;
      m.m_data   <= '0;
      m.m_valid  <= 1'b0;
      m.m_last   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_NONE;
`ifdef UART_FRAMER_CHKSUM_EN
      xr         <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      pend       <= rd_uart;
      rd_uart    <= !rx_empty && !rd_uart && !going_hold;
      case (state)
        S_HUNT: if (cap && r_data == SOF) state <= S_LEN;
        S_LEN: begin
          if (cap) begin
            if (r_data == 8'd0 || r_data > 8'(MAX_LEN)) begin
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
              state     <= S_HUNT;
            end else begin
              rem   <= r_data;
`ifdef UART_FRAMER_CHKSUM_EN
              xr    <= r_data;
`endif
              state <= S_DATA;
            end
          end else if (tmo) begin
            frame_err <= 1'b1;
            err_code  <= ERR_TMO;
            state     <= S_HUNT;
          end
        end
        S_DATA: begin
          if (cap) begin
`ifdef UART_FRAMER_CHKSUM_EN
            xr        <= xr ^ r_data;
`endif
            m.m_data  <= r_data;
            m.m_valid <= 1'b1;
            m.m_last  <= (rem == 8'd1);
            state     <= S_HOLD;
          end else if (tmo) begin
            frame_err <= 1'b1;
            err_code  <= ERR_TMO;
            state     <= S_HUNT;
          end
        end
        S_HOLD: begin
          if (m.m_ready) begin
            m.m_valid <= 1'b0;
            m.m_last  <= 1'b0;
            rem       <= rem - 8'd1;
            if (rem == 8'd1) begin
`ifdef UART_FRAMER_CHKSUM_EN
              state      <= S_CHK;
`else
              frame_done <= 1'b1;
              state      <= S_HUNT;
`endif
            end else begin
              state <= S_DATA;
            end
          end
        end
`ifdef UART_FRAMER_CHKSUM_EN
        S_CHK: begin
          if (cap) begin
            if (r_data == xr) begin
              frame_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CHK;
            end
            state <= S_HUNT;
          end else if (tmo) begin
            frame_err <= 1'b1;
            err_code  <= ERR_TMO;
            state     <= S_HUNT;
          end
        end
`endif
        default: state <= S_HUNT;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: FIFO model, payload/event scoreboard, frame table.
module tb_uart_rx_framer;
  import uart_pkg::*;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 50;
`ifdef UART_FRAMER_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] r_data = 8'h00;
  logic       rx_empty = 1'b1;
  logic       rd_uart, frame_done, frame_err;
  logic [1:0] err_code;

  uart_rx_framer_if mif ();

  uart_rx_framer #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .r_data     (r_data),
    .rx_empty   (rx_empty),
    .rd_uart    (rd_uart),
    .m          (mif),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] bytes;   // first byte in the most significant used position
    int          nb;
    int          sof;     // index of the SOF that starts the checksummed span
    bit          add_chk;
    logic [31:0] pl;
    int          npl;
    int          ev;      // 0 = frame_done, else expected err_code
  } vec_t;

  int         n_checks = 0, n_err = 0;
  logic [7:0] fq[$];
  logic [8:0] exp_q[$];
  int         ev_q[$];
  vec_t       vt[$];
  logic       rd_prev = 1'b0, hold_prev = 1'b0;
  logic [8:0] hold_val = '0;
  int         rd_cnt = 0, hs_cnt = 0, cyc = 0, last_hs_cyc = 0, err_cyc = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Samples the settled cycle, then advances one clock and models the FIFO pop.
  task automatic tick();
    int code;
    if (hold_prev) chk("hold_stable", {mif.m_valid, mif.m_last, mif.m_data}, {1'b1, hold_val});
    if (mif.m_valid && mif.m_ready) begin
      hs_cnt++;
      last_hs_cyc = cyc;
      if (exp_q.size() == 0) chk("extra_byte", {mif.m_last, mif.m_data}, -1);
      else chk("payload", {mif.m_last, mif.m_data}, exp_q.pop_front());
    end
    hold_prev = reset_n && mif.m_valid && !mif.m_ready;
    hold_val  = {mif.m_last, mif.m_data};
    if (frame_done && frame_err) chk("done_and_err", 1, 0);
    else if (frame_done || frame_err) begin
      code = frame_done ? 0 : int'(err_code);
      if (frame_err) err_cyc = cyc;
      if (ev_q.size() == 0) chk("extra_event", code, -1);
      else chk("frame_event", code, ev_q.pop_front());
    end
    if (rd_uart) rd_cnt++;
    rd_prev = rd_uart;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_prev && fq.size() > 0) r_data = fq.pop_front();
    rx_empty = (fq.size() == 0);
  endtask

  task automatic push_vec(input vec_t v);
    logic [7:0] x, b;
    x = 8'h00;
    for (int i = 0; i < v.nb; i++) begin
      b = v.bytes[8*(v.nb-1-i) +: 8];
      fq.push_back(b);
      if (i > v.sof) x = x ^ b;
    end
    if (CHK_EN && v.add_chk) fq.push_back(x);
    for (int i = 0; i < v.npl; i++)
      exp_q.push_back({(i == v.npl - 1), v.pl[8*(v.npl-1-i) +: 8]});
    ev_q.push_back(v.ev);
    rx_empty = (fq.size() == 0);
  endtask

  task automatic run_idle(input int bound, input bit rand_ready);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ev_q.size() != 0) && n < bound) begin
      mif.m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      n++;
    end
    if (exp_q.size() != 0 || ev_q.size() != 0)
      chk("wait_bound", exp_q.size() + ev_q.size(), 0);
    mif.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    logic [7:0] x, b;
    int n, rd_base, d;
    mif.m_ready = 1'b0;

    vt.push_back('{64'h7E_03_11_22_33, 5, 0, 1'b1, 32'h11_22_33, 3, 0});
    vt.push_back('{64'hAA_55_7E_01_7E, 5, 2, 1'b1, 32'h7E, 1, 0});
    vt.push_back('{64'h7E_00, 2, 0, 1'b0, 32'h0, 0, 1});
    vt.push_back('{64'h7E_11, 2, 0, 1'b0, 32'h0, 0, 1});
    vt.push_back('{64'h7E_01_A5, 3, 0, 1'b1, 32'hA5, 1, 0});
    vt.push_back('{64'h7E_04_7E_00_FF_7E, 6, 0, 1'b1, 32'h7E_00_FF_7E, 4, 0});
`ifdef UART_FRAMER_CHKSUM_EN
    vt.push_back('{64'h7E_02_01_02_00, 5, 0, 1'b0, 32'h01_02, 2, 2});
    vt.push_back('{64'h7E_01_33, 3, 0, 1'b1, 32'h33, 1, 0});
`endif

    // Reset state
    for (int i = 0; i < 3; i++) tick();
    chk("reset_outs", {rd_uart, mif.m_valid, mif.m_last, frame_done, frame_err, err_code, mif.m_data}, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Frame table
    for (int k = 0; k < vt.size(); k++) begin
      push_vec(vt[k]);
      run_idle(600, k[0]);
    end
    chk("err_code_hold", err_code, CHK_EN ? 2 : 1);

    // Maximum length frame with random back-pressure
    x = 8'h10;
    fq.push_back(SOF);
    fq.push_back(8'h10);
    for (int i = 0; i < MAX_LEN; i++) begin
      b = 8'(i * 7 + 3);
      fq.push_back(b);
      x = x ^ b;
      exp_q.push_back({(i == MAX_LEN - 1), b});
    end
    if (CHK_EN) fq.push_back(x);
    ev_q.push_back(0);
    rx_empty = 1'b0;
    run_idle(1000, 1'b1);

    // Inter-byte timeout
    fq.push_back(SOF); fq.push_back(8'h02); fq.push_back(8'h01);
    rx_empty = 1'b0;
    exp_q.push_back({1'b0, 8'h01});
    ev_q.push_back(3);
    run_idle(400, 1'b0);
    d = err_cyc - last_hs_cyc;
    chk("tmo_latency", (d >= 51 && d <= 53) ? 52 : d, 52);
    chk("err_code_tmo", err_code, 3);

    // Back-pressure is not a timeout and blocks further fetches
    fq.push_back(SOF); fq.push_back(8'h02); fq.push_back(8'h01); fq.push_back(8'h02);
    if (CHK_EN) fq.push_back(8'h02 ^ 8'h01 ^ 8'h02);
    rx_empty = 1'b0;
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b1, 8'h02});
    ev_q.push_back(0);
    mif.m_ready = 1'b0;
    n = 0;
    while (!mif.m_valid && n < 50) begin tick(); n++; end
    chk("bp_valid_seen", mif.m_valid, 1);
    rd_base = rd_cnt;
    for (int i = 0; i < 200; i++) tick();
    chk("bp_no_fetch", rd_cnt - rd_base, 0);
    chk("bp_still_valid", {mif.m_valid, mif.m_data}, {1'b1, 8'h01});
    run_idle(200, 1'b0);

    // Reset mid-payload
    fq.push_back(SOF); fq.push_back(8'h04);
    fq.push_back(8'h01); fq.push_back(8'h02); fq.push_back(8'h03); fq.push_back(8'h04);
    if (CHK_EN) fq.push_back(8'h00);
    rx_empty = 1'b0;
    exp_q.push_back({1'b0, 8'h01});
    mif.m_ready = 1'b1;
    rd_base = hs_cnt;
    n = 0;
    while (hs_cnt == rd_base && n < 50) begin tick(); n++; end
    chk("rst_first_byte", hs_cnt - rd_base, 1);
    mif.m_ready = 1'b0;
    reset_n = 1'b0;
    tick();
    chk("rst_mid_outs", {rd_uart, mif.m_valid, mif.m_last, frame_done, frame_err, err_code, mif.m_data}, 0);
    fq.delete(); exp_q.delete(); ev_q.delete();
    rx_empty = 1'b1;
    reset_n = 1'b1;
    mif.m_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    push_vec(vt[0]);
    run_idle(600, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
